// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel stage: colour format, visible area, sync polarity
// and the box-update state encoding.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int unsigned H_VISIBLE = 800;
  localparam int unsigned V_VISIBLE = 600;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } upd_state_t;

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register carrying {HS,VS} so the syncs stay aligned with the pixel pipeline.
// Resets to all-ones, which is the inactive sync level.
module vga_sync_delay #(
  parameter int unsigned N = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] i_sync,
  output logic [1:0] o_sync
);

  logic [1:0] r_pipe [N];

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < N; i++) r_pipe[i] <= '1;
    end else begin
      r_pipe[0] <= i_sync;
      for (int unsigned i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_sync = r_pipe[N-1];

endmodule

// File: rtl/vga_box_renderer.sv
// Draws a solid box over a background colour; box updates are deferred to the next V_Sync_in fall.
// Optional build macro VGA_BOX_BORDER_EN adds a 1-pixel white frame on the box edges.
module vga_box_renderer
  import vga_pkg::*;
#(
  parameter int unsigned BOX_W      = 32,
  parameter int unsigned BOX_H      = 32,
  parameter int unsigned INIT_X     = 384,
  parameter int unsigned INIT_Y     = 284,
  parameter logic [11:0] INIT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        H_Sync_in,
  input  logic        V_Sync_in,
  input  logic        Active_Zone,
  input  logic [9:0]  X_pos,
  input  logic [9:0]  Y_pos,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [11:0] pos_color,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  upd_state_t r_state, w_next;
  logic       r_ready, r_vs_prev;
  logic       w_xfer, w_vs_fall;
  logic [9:0] r_pend_x, r_pend_y, r_box_x, r_box_y;
  rgb444_t    r_pend_color, r_box_color;

  assign w_xfer    = pos_valid && r_ready && (r_state == IDLE);
  assign w_vs_fall = (r_vs_prev != SYNC_ACTIVE) && (V_Sync_in == SYNC_ACTIVE);
  assign pos_ready = r_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_xfer) w_next = PENDING;
      PENDING: if (w_vs_fall) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_vs_prev    <= ~SYNC_ACTIVE;
      r_pend_x     <= '0;
      r_pend_y     <= '0;
      r_pend_color <= '0;
      r_box_x      <= 10'(INIT_X);
      r_box_y      <= 10'(INIT_Y);
      r_box_color  <= INIT_COLOR;
    end else begin
      r_state   <= w_next;
      r_ready   <= (w_next == IDLE);
      r_vs_prev <= V_Sync_in;
      if (w_xfer) begin
        r_pend_x     <= pos_x;
        r_pend_y     <= pos_y;
        r_pend_color <= pos_color;
      end
      if (r_state == COMMIT) begin
        r_box_x     <= r_pend_x;
        r_box_y     <= r_pend_y;
        r_box_color <= r_pend_color;
      end
    end
  end

  // Position is forced to zero outside the active zone so undriven X_pos/Y_pos never reach the compares.
  logic [10:0] w_x, w_y, w_bx, w_by, w_bx_end, w_by_end;
  logic        w_hit;

  assign w_x      = Active_Zone ? {1'b0, X_pos} : '0;
  assign w_y      = Active_Zone ? {1'b0, Y_pos} : '0;
  assign w_bx     = {1'b0, r_box_x};
  assign w_by     = {1'b0, r_box_y};
  assign w_bx_end = w_bx + 11'(BOX_W);
  assign w_by_end = w_by + 11'(BOX_H);
  assign w_hit    = (w_x >= w_bx) && (w_x < w_bx_end) && (w_x < 11'(H_VISIBLE)) &&
                    (w_y >= w_by) && (w_y < w_by_end) && (w_y < 11'(V_VISIBLE));

  logic    r_az, r_hit;
  rgb444_t w_fill, w_pix, r_rgb;

`ifdef VGA_BOX_BORDER_EN
  logic w_edge, r_edge;
  assign w_edge = (w_x == w_bx) || (w_x == w_bx_end - 11'd1) ||
                  (w_y == w_by) || (w_y == w_by_end - 11'd1);
  always_ff @(posedge CLOCK) begin
    if (!RESET) r_edge <= 1'b0;
    else        r_edge <= w_edge;
  end
  assign w_fill = r_edge ? rgb444_t'(12'hFFF) : r_box_color;
`else
  assign w_fill = r_box_color;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_az  <= 1'b0;
      r_hit <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_az  <= Active_Zone;
      r_hit <= Active_Zone && w_hit;
      r_rgb <= w_pix;
    end
  end

  always_comb begin
    w_pix = '0;
    if (r_az) w_pix = r_hit ? w_fill : rgb444_t'(BG_COLOR);
  end

  assign VGA_R = r_rgb.r;
  assign VGA_G = r_rgb.g;
  assign VGA_B = r_rgb.b;

  logic [1:0] w_sync_out;

  vga_sync_delay #(.N(2)) u_sync_delay (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .i_sync ({H_Sync_in, V_Sync_in}),
    .o_sync (w_sync_out)
  );

  assign VGA_HS = w_sync_out[1];
  assign VGA_VS = w_sync_out[0];

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed-vector bench for vga_box_renderer (default build, border macro undefined).
module tb_vga_box_renderer;

  logic       CLOCK = 1'b0;
  logic       RESET, H_Sync_in, V_Sync_in, Active_Zone, pos_valid, pos_ready;
  logic [9:0] X_pos, Y_pos, pos_x, pos_y;
  logic [11:0] pos_color;
  logic [3:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [11:0] rgb;

  always #10 CLOCK = ~CLOCK;

  vga_box_renderer #(
    .BOX_W(32), .BOX_H(32), .INIT_X(790), .INIT_Y(10),
    .INIT_COLOR(12'h00F), .BG_COLOR(12'h000)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .H_Sync_in(H_Sync_in), .V_Sync_in(V_Sync_in),
    .Active_Zone(Active_Zone), .X_pos(X_pos), .Y_pos(Y_pos),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y),
    .pos_color(pos_color), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one pixel and return the RGB it produces two rising edges later.
  task automatic px(input logic az, input int unsigned x, input int unsigned y, output logic [11:0] c);
    @(negedge CLOCK);
    Active_Zone = az;
    X_pos = 10'(x);
    Y_pos = 10'(y);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1 c = {VGA_R, VGA_G, VGA_B};
  endtask

  task automatic pix_check(input string tag, input int unsigned x, input int unsigned y,
                           input logic [11:0] exp);
    logic [11:0] c;
    px(1'b1, x, y, c);
    check(tag, 32'(c), 32'(exp));
  endtask

  task automatic xfer(input int unsigned x, input int unsigned y, input logic [11:0] c);
    @(negedge CLOCK);
    check("ready_before_xfer", 32'(pos_ready), 32'd1);
    pos_valid = 1'b1;
    pos_x = 10'(x);
    pos_y = 10'(y);
    pos_color = c;
    @(negedge CLOCK);
    pos_valid = 1'b0;
    pos_x = '0;
    pos_y = '0;
    pos_color = 12'hABC;
    check("ready_after_xfer", 32'(pos_ready), 32'd0);
  endtask

  task automatic vsync_pulse();
    @(negedge CLOCK);
    Active_Zone = 1'b0;
    V_Sync_in = 1'b0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    V_Sync_in = 1'b1;
    repeat (2) @(posedge CLOCK);
  endtask

  initial begin
    RESET = 1'b0; H_Sync_in = 1'b0; V_Sync_in = 1'b1; Active_Zone = 1'b0;
    X_pos = '0; Y_pos = '0; pos_valid = 1'b0; pos_x = '0; pos_y = '0; pos_color = '0;

    // Reset held 3 cycles with H_Sync_in low: outputs must stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
      check("rst_hs", 32'(VGA_HS), 32'd1);
      check("rst_vs", 32'(VGA_VS), 32'd1);
      check("rst_ready", 32'(pos_ready), 32'd1);
    end
    RESET = 1'b1;
    H_Sync_in = 1'b1;

    px(1'b0, 795, 20, rgb);
    check("az0_inside_box", 32'(rgb), 32'h0);

    // Initial box at (790,10) clipped at the right edge.
    pix_check("clip_790", 790, 10, 12'h00F);
    pix_check("clip_799", 799, 10, 12'h00F);
    pix_check("clip_789", 789, 10, 12'h000);
    pix_check("clip_col0", 0, 10, 12'h000);
    pix_check("clip_y41", 795, 41, 12'h00F);
    pix_check("clip_y42", 795, 42, 12'h000);

    // New box (100,50) F00, visible only after the frame boundary.
    xfer(100, 50, 12'hF00);
    pix_check("pending_old_box", 795, 10, 12'h00F);
    pix_check("pending_new_absent", 100, 50, 12'h000);
    vsync_pulse();
    check("ready_after_commit", 32'(pos_ready), 32'd1);
    pix_check("hit_x99", 99, 50, 12'h000);
    pix_check("hit_x100", 100, 50, 12'hF00);
    pix_check("hit_x131", 131, 50, 12'hF00);
    pix_check("hit_x132", 132, 50, 12'h000);
    pix_check("hit_y49", 100, 49, 12'h000);
    pix_check("hit_y81", 100, 81, 12'hF00);
    pix_check("hit_y82", 100, 82, 12'h000);
    pix_check("old_box_gone", 795, 10, 12'h000);

    // Deferred update issued mid-frame at line 300.
    @(negedge CLOCK);
    Active_Zone = 1'b1; X_pos = 10'd400; Y_pos = 10'd300;
    xfer(200, 60, 12'h0F0);
    pix_check("defer_old", 100, 50, 12'hF00);
    pix_check("defer_new_absent", 200, 60, 12'h000);
    check("defer_ready_low", 32'(pos_ready), 32'd0);
    vsync_pulse();
    check("defer_ready_high", 32'(pos_ready), 32'd1);
    pix_check("defer_new", 200, 60, 12'h0F0);
    pix_check("defer_old_gone", 100, 50, 12'h000);

    // Transfer on the same edge as a V_Sync_in fall: commit waits one frame.
    @(negedge CLOCK);
    Active_Zone = 1'b0;
    pos_valid = 1'b1; pos_x = 10'd300; pos_y = 10'd70; pos_color = 12'h0FF;
    V_Sync_in = 1'b0;
    @(negedge CLOCK);
    pos_valid = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    V_Sync_in = 1'b1;
    check("simul_ready_low", 32'(pos_ready), 32'd0);
    pix_check("simul_old", 200, 60, 12'h0F0);
    pix_check("simul_new_absent", 300, 70, 12'h000);
    vsync_pulse();
    pix_check("simul_new", 300, 70, 12'h0FF);
    check("simul_ready_high", 32'(pos_ready), 32'd1);

    // Sync outputs lag their inputs by exactly two edges.
    @(negedge CLOCK);
    H_Sync_in = 1'b0; V_Sync_in = 1'b0;
    @(posedge CLOCK); #1;
    check("hs_lag1", 32'(VGA_HS), 32'd1);
    check("vs_lag1", 32'(VGA_VS), 32'd1);
    @(posedge CLOCK); #1;
    check("hs_lag2", 32'(VGA_HS), 32'd0);
    check("vs_lag2", 32'(VGA_VS), 32'd0);
    @(negedge CLOCK);
    H_Sync_in = 1'b1; V_Sync_in = 1'b1;
    @(posedge CLOCK); #1;
    check("hs_rise_lag1", 32'(VGA_HS), 32'd0);
    @(posedge CLOCK); #1;
    check("hs_rise_lag2", 32'(VGA_HS), 32'd1);

    // Reset while PENDING discards the pending box and restores the initial one.
    xfer(400, 100, 12'hF0F);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(posedge CLOCK); #1;
    check("midrst_ready", 32'(pos_ready), 32'd1);
    @(negedge CLOCK);
    RESET = 1'b1;
    pix_check("midrst_init_box", 790, 10, 12'h00F);
    pix_check("midrst_prev_gone", 300, 70, 12'h000);
    vsync_pulse();
    pix_check("midrst_no_commit", 400, 100, 12'h000);
    pix_check("midrst_init_kept", 799, 41, 12'h00F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
